// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational lookup, registered mispredict flush/redirect and saturating statistics.
module branch_predictor #(
   parameter int unsigned ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_actual_pc,
   input  logic [31:0] upd_pred_pc,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   logic              flush_q;
   logic [31:0]       redirect_q;
   logic [31:0]       branches_q;
   logic [31:0]       mispred_q;

   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_hit;

   logic [IDX_W-1:0]  up_idx;
   logic [TAG_W-1:0]  up_tag;
   logic              up_hit;
   logic [1:0]        up_ctr_next;
   logic              mispredict;

   // Lookup reads registered state only, so a same-cycle update is invisible until the next cycle.
   always_comb begin
      lk_idx     = if_pc[IDX_W+1:2];
      lk_tag     = if_pc[31:IDX_W+2];
      lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken = lk_hit && ctr_q[lk_idx][1];
      pred_pc    = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;
   end

   always_comb begin
      up_idx      = upd_pc[IDX_W+1:2];
      up_tag      = upd_pc[31:IDX_W+2];
      up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_ctr_next = ctr_q[up_idx];
      if (upd_taken) begin
         if (ctr_q[up_idx] != 2'b11) up_ctr_next = ctr_q[up_idx] + 2'b01;
      end else begin
         if (ctr_q[up_idx] != 2'b00) up_ctr_next = ctr_q[up_idx] - 2'b01;
      end
      mispredict  = upd_valid && (upd_actual_pc != upd_pred_pc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tag_q[i]    <= '0;
            ctr_q[i]    <= 2'b01;
            target_q[i] <= '0;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            ctr_q[up_idx] <= up_ctr_next;
            if (upd_taken) target_q[up_idx] <= upd_actual_pc;
         end else if (upd_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            ctr_q[up_idx]    <= 2'b10;
            target_q[up_idx] <= upd_actual_pc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q    <= 1'b0;
         redirect_q <= '0;
         branches_q <= '0;
         mispred_q  <= '0;
      end else begin
         flush_q <= mispredict;
         if (mispredict) redirect_q <= upd_actual_pc;
         if (upd_valid && (branches_q != 32'hFFFF_FFFF)) branches_q <= branches_q + 32'd1;
         if (mispredict && (mispred_q != 32'hFFFF_FFFF)) mispred_q <= mispred_q + 32'd1;
      end
   end

   assign flush         = flush_q;
   assign redirect_pc   = redirect_q;
   assign stat_branches = branches_q;
   assign stat_mispred  = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16: index pc[5:2], tag pc[31:6]).
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_actual_pc;
   logic [31:0] upd_pred_pc;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   int vectors = 0;
   int miscompares = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_pc        (if_pc),
      .pred_taken   (pred_taken),
      .pred_pc      (pred_pc),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_actual_pc(upd_actual_pc),
      .upd_pred_pc  (upd_pred_pc),
      .flush        (flush),
      .redirect_pc  (redirect_pc),
      .stat_branches(stat_branches),
      .stat_mispred (stat_mispred)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] act, input logic [31:0] prd);
      upd_valid     = v;
      upd_pc        = pc;
      upd_taken     = tk;
      upd_actual_pc = act;
      upd_pred_pc   = prd;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      if_pc = 32'h0000_1000;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      #12;
      check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
      check("rst_pred_pc", pred_pc, 32'h0000_1004);
      check("rst_flush", {31'b0, flush}, 32'd0);
      check("rst_redirect", redirect_pc, 32'h0);
      check("rst_branches", stat_branches, 32'd0);
      check("rst_mispred", stat_mispred, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      // Allocate 0x1000 taken -> mispredict vs. fall-through prediction
      drive(1'b1, 32'h1000, 1'b1, 32'h1040, 32'h1004);
      step();
      check("alloc_flush", {31'b0, flush}, 32'd1);
      check("alloc_redirect", redirect_pc, 32'h1040);
      check("alloc_mispred", stat_mispred, 32'd1);
      check("alloc_branches", stat_branches, 32'd1);
      check("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
      check("alloc_pred_pc", pred_pc, 32'h1040);

      // Not taken, predicted 0x1040 -> mispredict, ctr 2->1
      @(negedge clk);
      drive(1'b1, 32'h1000, 1'b0, 32'h1004, 32'h1040);
      step();
      check("nt1_flush", {31'b0, flush}, 32'd1);
      check("nt1_redirect", redirect_pc, 32'h1004);
      check("nt1_mispred", stat_mispred, 32'd2);
      check("nt1_pred_taken", {31'b0, pred_taken}, 32'd0);
      check("nt1_pred_pc", pred_pc, 32'h1004);

      // Not taken, predicted correctly -> no flush, ctr 1->0
      @(negedge clk);
      drive(1'b1, 32'h1000, 1'b0, 32'h1004, 32'h1004);
      step();
      check("nt2_flush", {31'b0, flush}, 32'd0);
      check("nt2_redirect_hold", redirect_pc, 32'h1004);
      check("nt2_mispred", stat_mispred, 32'd2);
      check("nt2_branches", stat_branches, 32'd3);

      // Taken once from ctr=0 -> ctr=1, still predicts not taken
      @(negedge clk);
      drive(1'b1, 32'h1000, 1'b1, 32'h1100, 32'h1100);
      step();
      check("t_from0_pred_taken", {31'b0, pred_taken}, 32'd0);
      check("t_from0_flush", {31'b0, flush}, 32'd0);

      // 0x1040 aliases index 0 with a different tag -> overwrites entry
      @(negedge clk);
      drive(1'b1, 32'h1040, 1'b1, 32'h2000, 32'h1044);
      step();
      check("alias_mispred", stat_mispred, 32'd3);
      check("alias_old_pred_pc", pred_pc, 32'h1004);
      if_pc = 32'h1040;
      #1;
      check("alias_new_pred_taken", {31'b0, pred_taken}, 32'd1);
      check("alias_new_pred_pc", pred_pc, 32'h2000);

      // Same-cycle update and lookup of 0x2000
      @(negedge clk);
      if_pc = 32'h2000;
      drive(1'b1, 32'h2000, 1'b1, 32'h3000, 32'h2004);
      #1;
      check("same_cyc_old_pred", pred_pc, 32'h2004);
      step();
      check("same_cyc_new_taken", {31'b0, pred_taken}, 32'd1);
      check("same_cyc_new_pred", pred_pc, 32'h3000);
      check("same_cyc_branches", stat_branches, 32'd6);

      // Idle cycle with mismatching upd_* must be ignored
      @(negedge clk);
      drive(1'b0, 32'h2000, 1'b0, 32'h5000, 32'h6000);
      step();
      check("idle_flush", {31'b0, flush}, 32'd0);
      check("idle_branches", stat_branches, 32'd6);
      check("idle_pred_pc", pred_pc, 32'h3000);

      // Mispredict counter saturation
      @(negedge clk);
      force dut.mispred_q = 32'hFFFF_FFFE;
      #1;
      release dut.mispred_q;
      drive(1'b1, 32'h3000, 1'b1, 32'h3100, 32'h3004);
      step();
      check("sat1_mispred", stat_mispred, 32'hFFFF_FFFF);
      @(negedge clk);
      step();
      check("sat2_mispred", stat_mispred, 32'hFFFF_FFFF);
      check("sat2_flush", {31'b0, flush}, 32'd1);

      // Asynchronous reset mid-flush
      #2;
      rst_n = 1'b0;
      #1;
      check("async_flush", {31'b0, flush}, 32'd0);
      check("async_mispred", stat_mispred, 32'd0);
      check("async_branches", stat_branches, 32'd0);
      check("async_redirect", redirect_pc, 32'd0);
      check("async_pred_taken", {31'b0, pred_taken}, 32'd0);
      check("async_pred_pc", pred_pc, 32'h2004);

      // First edge after reset release accepts an update
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h3000, 1'b1, 32'h3100, 32'h3004);
      step();
      check("post_rst_flush", {31'b0, flush}, 32'd1);
      check("post_rst_redirect", redirect_pc, 32'h3100);
      check("post_rst_branches", stat_branches, 32'd1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if_pc = 32'h3000;
      step();
      check("post_rst_flush_drop", {31'b0, flush}, 32'd0);
      check("post_rst_pred_pc", pred_pc, 32'h3100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
